// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: adds two N*K-bit operands one N-bit chunk per cycle through a single ripple-carry adder.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);
    logic [N:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign c_o = c[N];
endmodule

module multiword_add_sequencer #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           carry_in,
    input  logic [N*K-1:0] op1,
    input  logic [N*K-1:0] op2,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*K-1:0] sum,
    output logic           carry_out,
    output logic           busy
);
    localparam int W  = N * K;
    localparam int IW = K > 1 ? $clog2(K) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
    logic          carry_q, carry_d, cout_q, cout_d;
    logic [N-1:0]  add_s;
    logic          add_c;
    ripple_carry_adder #(.N(N)) u_add (
        .a_i(op1_q[idx_q*N +: N]),
        .b_i(op2_q[idx_q*N +: N]),
        .c_i(carry_q),
        .s_o(add_s),
        .c_o(add_c)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start_valid) begin
                op1_d   = op1;
                op2_d   = op2;
                carry_d = carry_in;
                idx_d   = '0;
                sum_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q*N +: N] = add_s;
                carry_d = add_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(K - 1)) begin
                    cout_d  = add_c;
                    state_d = DONE;
                end
            end
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end
    // Result is valid exactly while waiting in DONE for the consumer.
    assign res_valid   = state_q == DONE;
    assign start_ready = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign sum         = sum_q;
    assign carry_out   = cout_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: directed and scoreboard checks for N=4/K=4, N=3/K=3 and N=4/K=1 sequencers.
module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;

    logic        sv, sr, ci, rv, rr, co, bz;
    logic [15:0] a, b, s;
    multiword_add_sequencer #(.N(4), .K(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(sv), .start_ready(sr), .carry_in(ci),
        .op1(a), .op2(b), .res_valid(rv), .res_ready(rr), .sum(s), .carry_out(co), .busy(bz)
    );

    logic       sv3, sr3, ci3, rv3, rr3, co3, bz3;
    logic [8:0] a3, b3, s3;
    multiword_add_sequencer #(.N(3), .K(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv3), .start_ready(sr3), .carry_in(ci3),
        .op1(a3), .op2(b3), .res_valid(rv3), .res_ready(rr3), .sum(s3), .carry_out(co3), .busy(bz3)
    );

    logic       sv1, sr1, ci1, rv1, rr1, co1, bz1;
    logic [3:0] a1, b1, s1;
    multiword_add_sequencer #(.N(4), .K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .carry_in(ci1),
        .op1(a1), .op2(b1), .res_valid(rv1), .res_ready(rr1), .sum(s1), .carry_out(co1), .busy(bz1)
    );

    task tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task test_reset;
        rst_n = 1'b0;
        {sv, ci, rr, sv3, ci3, rr3, sv1, ci1, rr1} = '0;
        a = '0; b = '0; a3 = '0; b3 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        checks++;
        if (s !== 16'h0 || co !== 1'b0 || rv !== 1'b0 || sr !== 1'b1 || bz !== 1'b0) begin
            errors++;
            $display("FAIL reset: sum=%h co=%b rv=%b sr=%b busy=%b want 0000 0 0 1 0", s, co, rv, sr, bz);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task test_carry_ripple;
        a = 16'hFFFF; b = 16'h0001; ci = 1'b0; rr = 1'b0; sv = 1'b1;
        tick;
        sv = 1'b0;
        checks++;
        if (bz !== 1'b1 || sr !== 1'b0) begin
            errors++;
            $display("FAIL run_flags: busy=%b sr=%b want 1 0", bz, sr);
        end
        repeat (3) tick;
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rv=%b want 0 after 3 cycles", rv);
        end
        tick;
        checks++;
        if (rv !== 1'b1 || s !== 16'h0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL ffff_plus_1: rv=%b sum=%h co=%b want 1 0000 1", rv, s, co);
        end
        rr = 1'b1;
        tick;
        rr = 1'b0;
        checks++;
        if (rv !== 1'b0 || sr !== 1'b1 || bz !== 1'b0 || s !== 16'h0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL return_idle: rv=%b sr=%b busy=%b sum=%h co=%b want 0 1 0 0000 1", rv, sr, bz, s, co);
        end
    endtask

    task test_res_ready_high;
        a = 16'h1234; b = 16'h4321; ci = 1'b1; rr = 1'b1; sv = 1'b1;
        tick;
        sv = 1'b0;
        repeat (3) tick;
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL rr_high_early: rv=%b want 0", rv);
        end
        tick;
        checks++;
        if (rv !== 1'b1 || s !== 16'h5556 || co !== 1'b0) begin
            errors++;
            $display("FAIL rr_high_result: rv=%b sum=%h co=%b want 1 5556 0", rv, s, co);
        end
        tick;
        checks++;
        if (rv !== 1'b0 || sr !== 1'b1) begin
            errors++;
            $display("FAIL rr_high_pulse: rv=%b sr=%b want 0 1", rv, sr);
        end
        rr = 1'b0;
    endtask

    task test_backpressure;
        a = 16'h8000; b = 16'h8000; ci = 1'b0; rr = 1'b0; sv = 1'b1;
        tick;
        repeat (4) tick;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rv !== 1'b1 || sr !== 1'b0 || s !== 16'h0000 || co !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: rv=%b sr=%b sum=%h co=%b want 1 0 0000 1", i, rv, sr, s, co);
            end
            tick;
        end
        sv = 1'b0;
        rr = 1'b1;
        tick;
        rr = 1'b0;
        checks++;
        if (rv !== 1'b0 || sr !== 1'b1 || bz !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rv=%b sr=%b busy=%b want 0 1 0", rv, sr, bz);
        end
    endtask

    task test_input_hold;
        a = 16'h00FF; b = 16'h0F0F; ci = 1'b0; rr = 1'b0; sv = 1'b1;
        tick;
        sv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ci = 1'($urandom);
            tick;
        end
        checks++;
        if (rv !== 1'b1 || s !== 16'h100E || co !== 1'b0) begin
            errors++;
            $display("FAIL input_hold: rv=%b sum=%h co=%b want 1 100e 0", rv, s, co);
        end
        rr = 1'b1;
        tick;
        rr = 1'b0;
    endtask

    task test_reset_abort;
        a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; rr = 1'b0; sv = 1'b1;
        tick;
        sv = 1'b0;
        repeat (2) tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s !== 16'h0 || co !== 1'b0 || rv !== 1'b0 || sr !== 1'b1 || bz !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: sum=%h co=%b rv=%b sr=%b busy=%b want 0000 0 0 1 0", s, co, rv, sr, bz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; ci = 1'b0; sv = 1'b1;
        tick;
        sv = 1'b0;
        repeat (4) tick;
        checks++;
        if (rv !== 1'b1 || s !== 16'h0002 || co !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: rv=%b sum=%h co=%b want 1 0002 0", rv, s, co);
        end
        rr = 1'b1;
        tick;
        rr = 1'b0;
    endtask

    task automatic test_regression_k3;
        logic [9:0] q[$];
        logic [9:0] e;
        int done = 0;
        int cyc = 0;
        while (done < 2000 && cyc < 60000) begin
            sv3 = $urandom_range(3) != 0;
            a3  = 9'($urandom);
            b3  = 9'($urandom);
            ci3 = 1'($urandom);
            rr3 = 1'($urandom);
            if (rv3 && rr3) begin
                checks++;
                done++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL k3_unexpected: got %h with empty scoreboard", {co3, s3});
                end else begin
                    e = q.pop_front();
                    if ({co3, s3} !== e) begin
                        errors++;
                        $display("FAIL k3_result: got %h want %h", {co3, s3}, e);
                    end
                end
            end
            if (sv3 && sr3) q.push_back({1'b0, a3} + {1'b0, b3} + 10'(ci3));
            tick;
            cyc++;
        end
        sv3 = 1'b0;
        rr3 = 1'b0;
        checks++;
        if (done < 2000) begin
            errors++;
            $display("FAIL k3_timeout: completed %0d of 2000", done);
        end
    endtask

    task test_k1_exhaustive;
        logic [4:0] e;
        rr1 = 1'b1;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 4'(x); b1 = 4'(y); ci1 = 1'(c); sv1 = 1'b1;
                    tick;
                    sv1 = 1'b0;
                    tick;
                    e = 5'(x + y + c);
                    checks++;
                    if (rv1 !== 1'b1 || {co1, s1} !== e) begin
                        errors++;
                        $display("FAIL k1_%0d_%0d_%0d: rv=%b got %h want %h", x, y, c, rv1, {co1, s1}, e);
                    end
                    tick;
                end
        rr1 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_carry_ripple;
        test_res_ready_high;
        test_backpressure;
        test_input_hold;
        test_reset_abort;
        test_regression_k3;
        test_k1_exhaustive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle sequencer that adds two W = N*K-bit operands with a single N-bit ripple_carry_adder instance.
- It feeds one N-bit chunk per clock, least-significant chunk first, and carries between chunks through a registered carry.
- It trades latency for area in wide datapaths.
- It uses a valid/ready handshake on both its input and result sides.

Parameters:
- N, 4, width in bits of the internal ripple_carry_adder (chunk width); N >= 1.
- K, 4, number of chunks per operation; K >= 1; total operand width W = N*K.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  requester has an operation on op1/op2/carry_in.
- start_ready  output  1  block can accept an operation.
- carry_in  input  1  carry into chunk 0.
- op1  input  W  first operand.
- op2  input  W  second operand.
- res_valid  output  1  sum/carry_out hold a completed result.
- res_ready  input  1  consumer accepts the result.
- sum  output  W  registered result.
- carry_out  output  1  carry out of chunk K-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - sum = 0, carry_out = 0, res_valid = 0, busy = 0, start_ready = 1.
  - Internal operand registers, chunk index and carry register are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On a rising edge with start_valid = 1:
    - latch op1, op2 and carry_in into internal registers;
    - set chunk index idx = 0 and clear sum;
    - go to RUN.
  - Inputs are sampled only on the accept edge; later changes are ignored.
- RUN:
  - start_ready = 0.
  - Each cycle, the adder sees op1_r[idx*N +: N], op2_r[idx*N +: N] and carry_r.
  - On each edge: write the adder sum into sum[idx*N +: N], set carry_r to the adder carry-out, and increment idx.
  - On the edge that processes idx = K-1: set carry_out to the final carry, set res_valid = 1, go to DONE.
  - RUN lasts exactly K cycles.
- DONE:
  - sum, carry_out and res_valid are held stable while res_ready = 0, for an unbounded time.
  - On an edge with res_ready = 1: res_valid goes to 0, go to IDLE.
  - sum and carry_out keep their last values until the next accept clears sum.
  - start_ready stays 0 in DONE; there is no overlap with a new operation.
- Latency: res_valid is first high K cycles after the accept edge.
  - Minimum initiation interval is K+2 cycles: accept, K RUN cycles, result handshake, return to IDLE.
- Arithmetic: {carry_out, sum} == op1 + op2 + carry_in, modulo 2^(W+1); this is exact, with no truncation.
- K = 1: RUN lasts one cycle; the block behaves as a registered N-bit adder with handshake.
- Mid-operation reset (RUN or DONE): the operation is aborted and all outputs take their reset values immediately. No partial result is ever flagged valid.
- start_valid held high in RUN or DONE has no effect; it is accepted only after the block returns to IDLE.
- res_ready high while res_valid = 0 is ignored.
- busy = (state != IDLE); start_ready = (state == IDLE).

Test Plan:
- N=4, K=4. Accept op1=16'hFFFF, op2=16'h0001, carry_in=0 -> exactly 4 cycles later res_valid=1, sum=16'h0000, carry_out=1.
- Accept op1=16'h1234, op2=16'h4321, carry_in=1, with res_ready tied high -> sum=16'h5556, carry_out=0. res_valid is high for exactly 1 cycle and start_ready returns to 1 on the next cycle.
- Backpressure: complete 16'h8000+16'h8000 with res_ready=0 for 6 cycles -> sum=16'h0000, carry_out=1, held stable, res_valid=1 and start_ready=0 throughout. Raising res_ready gives one transfer, then IDLE.
- Input-hold check: change op1/op2 to random values every cycle after accepting 16'h00FF+16'h0F0F, carry_in=0 -> result is 16'h100E with carry_out=0, unaffected by the changes.
- Reset abort: drop rst_n 2 cycles into RUN -> sum, carry_out and res_valid are 0 and start_ready is 1 without waiting for a clock edge. After release, a new accept of 16'h0001+16'h0001 yields 16'h0002.
- Regression: N=3, K=3 (W=9), with random back-to-back ops and random res_ready, >= 2000 ops -> each result equals the scoreboard value of op1+op2+carry_in. Also run K=1 with exhaustive 4-bit operands and both carry_in values.
